// File: rtl/multicycle_control.sv
// Multi-cycle sequencer for the SCU-ISA datapath: FETCH/DECODE/EXEC/MEM/WB with
// memory-ready handshake, timeout watchdog, sticky traps and a retired-instruction counter.
module multicycle_control #(
  parameter int OPCODE_W = 4,
  parameter int ALUOP_W  = 3,
  parameter int TIMEOUT  = 16,
  parameter int CNT_W    = 16
) (
  input  logic                in_clk,
  input  logic                in_rst_n,
  input  logic [OPCODE_W-1:0] in_opcode,
  input  logic                in_mem_ready,
  output logic                out_ctrl_irwrt,
  output logic                out_ctrl_pcwrt,
  output logic                out_ctrl_regwrt,
  output logic                out_ctrl_memrd,
  output logic                out_ctrl_memwrt,
  output logic                out_ctrl_alusrc,
  output logic [ALUOP_W-1:0]  out_ctrl_aluop,
  output logic                out_ctrl_memtoreg,
  output logic                out_ctrl_branch,
  output logic                out_ctrl_btype,
  output logic                out_ctrl_jump,
  output logic [2:0]          out_state,
  output logic                out_illegal,
  output logic                out_timeout,
  output logic [CNT_W-1:0]    out_retired
);

  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd7
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'd0,  OP_SVPC = 4'd1,  OP_LD  = 4'd2,  OP_ST  = 4'd3;
  localparam logic [3:0] OP_ADD  = 4'd4,  OP_INC  = 4'd5,  OP_NEG = 4'd6,  OP_SUB = 4'd7;
  localparam logic [3:0] OP_J    = 4'd8,  OP_BRZ  = 4'd9,  OP_JM  = 4'd10, OP_BRN = 4'd11;

  localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_INC   = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] ALU_NEG   = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] ALU_PASSB = ALUOP_W'(4);

  state_t        state, state_next;
  logic [3:0]    opcode_q;
  logic [TW-1:0] wcnt, wcnt_next;
  logic          legal, wait_limit, retire, set_illegal, set_timeout;

  // Only the low nibble is decoded, so it is all the opcode register keeps.
  assign legal      = ((in_opcode >> 4) == '0) && (in_opcode[3:0] < 4'd12);
  assign wait_limit = (wcnt == TW'(TIMEOUT - 1));
  assign out_state  = state;

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state       <= FETCH;
      opcode_q    <= '0;
      wcnt        <= '0;
      out_retired <= '0;
      out_illegal <= 1'b0;
      out_timeout <= 1'b0;
    end else begin
      state <= state_next;
      wcnt  <= wcnt_next;
      if (state == DECODE) opcode_q <= in_opcode[3:0];
      if (retire)          out_retired <= out_retired + CNT_W'(1);
      if (set_illegal)     out_illegal <= 1'b1;
      if (set_timeout)     out_timeout <= 1'b1;
    end
  end

  always_comb begin
    state_next        = state;
    wcnt_next         = '0;
    retire            = 1'b0;
    set_illegal       = 1'b0;
    set_timeout       = 1'b0;
    out_ctrl_irwrt    = 1'b0;
    out_ctrl_pcwrt    = 1'b0;
    out_ctrl_regwrt   = 1'b0;
    out_ctrl_memrd    = 1'b0;
    out_ctrl_memwrt   = 1'b0;
    out_ctrl_alusrc   = 1'b0;
    out_ctrl_aluop    = ALU_ADD;
    out_ctrl_memtoreg = 1'b0;
    out_ctrl_branch   = 1'b0;
    out_ctrl_btype    = 1'b0;
    out_ctrl_jump     = 1'b0;
    case (state)
      FETCH: begin
        out_ctrl_memrd = 1'b1;
        // Mealy strobes are held off while reset is asserted.
        out_ctrl_irwrt = in_mem_ready & in_rst_n;
        out_ctrl_pcwrt = in_mem_ready & in_rst_n;
        if (in_mem_ready) begin
          state_next = DECODE;
        end else if (wait_limit) begin
          state_next  = TRAP;
          set_timeout = 1'b1;
        end else begin
          wcnt_next = wcnt + TW'(1);
        end
      end
      DECODE: begin
        if (legal) begin
          state_next = EXEC;
        end else begin
          state_next  = TRAP;
          set_illegal = 1'b1;
        end
      end
      EXEC: begin
        state_next = FETCH;
        retire     = 1'b1;
        case (opcode_q)
          OP_ADD:  begin out_ctrl_aluop = ALU_ADD; state_next = WB; retire = 1'b0; end
          OP_SUB:  begin out_ctrl_aluop = ALU_SUB; state_next = WB; retire = 1'b0; end
          OP_INC:  begin out_ctrl_aluop = ALU_INC; state_next = WB; retire = 1'b0; end
          OP_NEG:  begin out_ctrl_aluop = ALU_NEG; state_next = WB; retire = 1'b0; end
          OP_SVPC: begin
            out_ctrl_aluop  = ALU_ADD;
            out_ctrl_alusrc = 1'b1;
            state_next      = WB;
            retire          = 1'b0;
          end
          OP_LD, OP_ST, OP_JM: begin
            out_ctrl_aluop = ALU_PASSB;
            state_next     = MEM;
            retire         = 1'b0;
          end
          OP_J:    out_ctrl_jump = 1'b1;
          OP_BRZ:  out_ctrl_branch = 1'b1;
          OP_BRN:  begin out_ctrl_branch = 1'b1; out_ctrl_btype = 1'b1; end
          default: ;
        endcase
      end
      MEM: begin
        if (opcode_q == OP_ST) out_ctrl_memwrt = 1'b1;
        else                   out_ctrl_memrd  = 1'b1;
        if (in_mem_ready) begin
          if (opcode_q == OP_LD) begin
            state_next = WB;
          end else begin
            state_next    = FETCH;
            retire        = 1'b1;
            out_ctrl_jump = (opcode_q == OP_JM);
          end
        end else if (wait_limit) begin
          state_next  = TRAP;
          set_timeout = 1'b1;
        end else begin
          wcnt_next = wcnt + TW'(1);
        end
      end
      WB: begin
        out_ctrl_regwrt   = 1'b1;
        out_ctrl_memtoreg = (opcode_q == OP_LD);
        state_next        = FETCH;
        retire            = 1'b1;
      end
      TRAP:    state_next = TRAP;
      default: state_next = TRAP;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed scenarios plus randomized
// instruction streams checked cycle-by-cycle against an instruction-level model.
module tb_multicycle_control;

  localparam int OW = 6;
  localparam int AW = 3;
  localparam int TO = 4;
  localparam int CW = 4;

  logic          in_clk = 1'b0;
  logic          in_rst_n = 1'b0;
  logic [OW-1:0] in_opcode = '0;
  logic          in_mem_ready = 1'b0;
  logic          out_ctrl_irwrt, out_ctrl_pcwrt, out_ctrl_regwrt, out_ctrl_memrd;
  logic          out_ctrl_memwrt, out_ctrl_alusrc, out_ctrl_memtoreg;
  logic          out_ctrl_branch, out_ctrl_btype, out_ctrl_jump;
  logic [AW-1:0] out_ctrl_aluop;
  logic [2:0]    out_state;
  logic          out_illegal, out_timeout;
  logic [CW-1:0] out_retired;

  multicycle_control #(.OPCODE_W(OW), .ALUOP_W(AW), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .in_clk(in_clk), .in_rst_n(in_rst_n), .in_opcode(in_opcode), .in_mem_ready(in_mem_ready),
    .out_ctrl_irwrt(out_ctrl_irwrt), .out_ctrl_pcwrt(out_ctrl_pcwrt),
    .out_ctrl_regwrt(out_ctrl_regwrt), .out_ctrl_memrd(out_ctrl_memrd),
    .out_ctrl_memwrt(out_ctrl_memwrt), .out_ctrl_alusrc(out_ctrl_alusrc),
    .out_ctrl_aluop(out_ctrl_aluop), .out_ctrl_memtoreg(out_ctrl_memtoreg),
    .out_ctrl_branch(out_ctrl_branch), .out_ctrl_btype(out_ctrl_btype),
    .out_ctrl_jump(out_ctrl_jump), .out_state(out_state),
    .out_illegal(out_illegal), .out_timeout(out_timeout), .out_retired(out_retired)
  );

  always #5 in_clk = ~in_clk;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_retired;
  bit exp_ill, exp_to, trapped;

  logic [15:0] obs;
  logic [5:0]  flags;
  assign obs = {out_state, out_ctrl_irwrt, out_ctrl_pcwrt, out_ctrl_regwrt, out_ctrl_memrd,
                out_ctrl_memwrt, out_ctrl_alusrc, out_ctrl_aluop, out_ctrl_memtoreg,
                out_ctrl_branch, out_ctrl_btype, out_ctrl_jump};
  assign flags = {out_illegal, out_timeout, out_retired};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] ctl(input logic [2:0] st, input logic irw, input logic pcw,
                                      input logic regw, input logic mrd, input logic mwr,
                                      input logic asrc, input logic [2:0] aop, input logic m2r,
                                      input logic br, input logic bt, input logic jmp);
    return {st, irw, pcw, regw, mrd, mwr, asrc, aop, m2r, br, bt, jmp};
  endfunction

  function automatic logic [5:0] exp_flags();
    return {exp_ill, exp_to, CW'(exp_retired)};
  endfunction

  function automatic logic rbit();
    return 1'($urandom);
  endfunction

  function automatic logic [OW-1:0] rop();
    return OW'($urandom);
  endfunction

  // Drive inputs just after a rising edge, check at the falling edge.
  task automatic step(input logic rdy, input logic [OW-1:0] opc, input logic [15:0] e, input string tag);
    in_mem_ready = rdy;
    in_opcode    = opc;
    @(negedge in_clk);
    check(tag, 32'(obs), 32'(e));
    check({tag, "_flags"}, 32'(flags), 32'(exp_flags()));
    @(posedge in_clk);
    #1;
  endtask

  task automatic do_reset();
    exp_retired = 0;
    exp_ill     = 0;
    exp_to      = 0;
    trapped     = 0;
    in_rst_n    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_mem_ready = 1'b1;
      in_opcode    = rop();
      @(negedge in_clk);
      check("reset", 32'(obs), 32'(ctl(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0)));
      check("reset_flags", 32'(flags), 32'(exp_flags()));
      @(posedge in_clk);
      #1;
    end
    in_rst_n = 1'b1;
  endtask

  task automatic trap_hold(input int n);
    for (int i = 0; i < n; i++)
      step(rbit(), rop(), ctl(7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "trap");
  endtask

  // One instruction: fw / mw are the not-ready cycles before memory answers in FETCH / MEM.
  task automatic do_instr(input logic [OW-1:0] op, input int fw, input int mw);
    logic [3:0] o;
    logic       r;
    int         nxt;
    logic [15:0] e;
    for (int w = 0; w < TO; w++) begin
      r = (w >= fw);
      step(r, rop(), ctl(0, r, r, 0, 1, 0, 0, 0, 0, 0, 0, 0), "fetch");
      if (r) break;
      if (w == TO - 1) begin
        exp_to = 1; trapped = 1;
        return;
      end
    end
    step(rbit(), op, ctl(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "decode");
    if (op >= 12) begin
      exp_ill = 1; trapped = 1;
      return;
    end
    o = op[3:0];
    nxt = 0;
    e = ctl(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    case (o)
      4'd1:  begin e = ctl(2, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0); nxt = 2; end
      4'd2, 4'd3, 4'd10: begin e = ctl(2, 0, 0, 0, 0, 0, 0, 4, 0, 0, 0, 0); nxt = 1; end
      4'd4:  begin e = ctl(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); nxt = 2; end
      4'd5:  begin e = ctl(2, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0); nxt = 2; end
      4'd6:  begin e = ctl(2, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0); nxt = 2; end
      4'd7:  begin e = ctl(2, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0); nxt = 2; end
      4'd8:  e = ctl(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      4'd9:  e = ctl(2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      4'd11: e = ctl(2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
      default: ;
    endcase
    step(rbit(), rop(), e, "exec");
    if (nxt == 0) begin
      exp_retired++;
      return;
    end
    if (nxt == 1) begin
      for (int w = 0; w < TO; w++) begin
        r = (w >= mw);
        step(r, rop(), ctl(3, 0, 0, 0, o != 3, o == 3, 0, 0, 0, 0, 0, (o == 10) && r), "mem");
        if (r) break;
        if (w == TO - 1) begin
          exp_to = 1; trapped = 1;
          return;
        end
      end
      if (o != 2) begin
        exp_retired++;
        return;
      end
    end
    step(rbit(), rop(), ctl(4, 0, 0, 1, 0, 0, 0, 0, o == 2, 0, 0, 0), "wb");
    exp_retired++;
  endtask

  initial begin
    logic [OW-1:0] op;
    int fw, mw;
    do_reset();

    do_instr(4, 0, 0);
    check("add_retired", 32'(out_retired), 32'd1);
    do_reset();
    do_instr(2, 0, 3);
    check("ld_retired", 32'(out_retired), 32'd1);
    do_instr(9, 1, 0);
    do_instr(11, 0, 0);
    do_instr(8, 2, 0);
    do_instr(10, 0, 2);
    check("branch_retired", 32'(out_retired), 32'd5);

    do_reset();
    do_instr(13, 0, 0);
    trap_hold(20);
    check("illegal_13", 32'(out_illegal), 32'd1);
    do_reset();
    do_instr(6'h24, 0, 0);
    trap_hold(20);
    check("illegal_upper", 32'(out_illegal), 32'd1);

    do_reset();
    do_instr(3, 0, TO);
    trap_hold(3);
    check("st_timeout", 32'(out_timeout), 32'd1);
    do_reset();
    do_instr(3, 0, TO - 1);
    do_instr(0, TO - 1, 0);
    check("ready_wins", 32'({out_timeout, out_retired}), 32'd2);
    do_reset();
    do_instr(0, TO, 0);
    trap_hold(2);

    // Asynchronous reset during a store wait.
    do_reset();
    step(1, rop(), ctl(0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0), "fetch");
    step(0, 3, ctl(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "decode");
    step(0, rop(), ctl(2, 0, 0, 0, 0, 0, 0, 4, 0, 0, 0, 0), "exec");
    step(0, rop(), ctl(3, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), "mem");
    in_mem_ready = 1'b0;
    @(negedge in_clk);
    check("mem_pre_reset", 32'(obs), 32'(ctl(3, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0)));
    #2;
    in_rst_n = 1'b0;
    #1;
    check("async_reset", 32'(obs), 32'(ctl(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0)));
    @(posedge in_clk);
    #1;
    do_reset();

    for (int i = 0; i < 17; i++) do_instr(0, 0, 0);
    check("wrap", 32'(out_retired), 32'd1);

    do_reset();
    for (int i = 0; i < 300; i++) begin
      op = ($urandom % 20 == 0) ? OW'(16 + $urandom % 48) : OW'($urandom % 16);
      fw = ($urandom % 12 == 0) ? TO : int'($urandom_range(0, TO - 1));
      mw = ($urandom % 12 == 0) ? TO : int'($urandom_range(0, TO - 1));
      do_instr(op, fw, mw);
      if (trapped) begin
        trap_hold(3);
        do_reset();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
